// File: rtl/psg_bus_master.sv
// Hardware bus initiator for the dual-AY port protocol (0xFFFD select / 0xBFFD data).
// Build option: define PSG_READBACK_EN to enable register reads; otherwise read commands are dropped.
module psg_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_LEN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_chip,
  input  logic        cmd_read,
  input  logic [3:0]  cmd_reg,
  input  logic [7:0]  cmd_val,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        iorq,
  output logic        wr,
  output logic        rd,
  output logic [15:0] a,
  output logic [7:0]  d,
  input  logic [7:0]  q
);

  typedef struct packed {
    logic       chip;
    logic       rd;
    logic [3:0] rg;
    logic [7:0] val;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;
  typedef enum logic [1:0] {K_CHIPSEL, K_REGSEL, K_DATA} kind_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_LEN - 1);

  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  cmd_t        mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full, push, pop;
  cmd_t        head;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_chip, cmd_read, cmd_reg, cmd_val};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  state_e      state_q;
  kind_e       kind_q;
  logic [CW-1:0] cnt_q;
  logic        chip_q;
  cmd_t        cur_q;
  logic        iorq_q, wr_q;
  logic [15:0] a_q;
  logic [7:0]  d_q;
`ifdef PSG_READBACK_EN
  logic        rd_q, rvalid_q;
  logic [7:0]  rdata_q;
`endif

  // Address/data presented in SETUP for a given cycle kind; reads leave d as it was.
  function automatic logic [23:0] bus_ad(input kind_e k, input cmd_t c, input logic [7:0] d_hold);
    case (k)
      K_CHIPSEL: bus_ad = {16'hFFFD, 7'h7F, ~c.chip};
      K_REGSEL:  bus_ad = {16'hFFFD, 4'h0, c.rg};
      default:   bus_ad = c.rd ? {16'hFFFD, d_hold} : {16'hBFFD, c.val};
    endcase
  endfunction

  kind_e       launch_kind, next_kind;
  logic        launch_ok;
  logic [23:0] launch_ad, next_ad;

  assign pop = ce && !empty && (state_q == S_IDLE || (state_q == S_HOLD && kind_q == K_DATA));

  always_comb begin
    launch_kind = (head.chip != chip_q) ? K_CHIPSEL : K_REGSEL;
    next_kind   = (kind_q == K_CHIPSEL) ? K_REGSEL : K_DATA;
`ifdef PSG_READBACK_EN
    launch_ok   = 1'b1;
`else
    launch_ok   = !head.rd;
`endif
  end

  assign launch_ad = bus_ad(launch_kind, head, d_q);
  assign next_ad   = bus_ad(next_kind, cur_q, d_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_REGSEL;
      cnt_q    <= '0;
      chip_q   <= 1'b0;
      cur_q    <= '0;
      iorq_q   <= 1'b1;
      wr_q     <= 1'b1;
      a_q      <= 16'hFFFF;
      d_q      <= 8'h00;
`ifdef PSG_READBACK_EN
      rd_q     <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
`endif
    end else begin
`ifdef PSG_READBACK_EN
      rvalid_q <= 1'b0;
`endif
      if (ce) begin
        case (state_q)
          S_IDLE, S_HOLD: begin
            if (state_q == S_HOLD && kind_q != K_DATA) begin
              if (kind_q == K_CHIPSEL) chip_q <= cur_q.chip;
              kind_q     <= next_kind;
              {a_q, d_q} <= next_ad;
              state_q    <= S_SETUP;
            end else if (pop) begin
              // The pop tick doubles as SETUP of the first bus cycle.
              cur_q <= head;
              if (launch_ok) begin
                kind_q     <= launch_kind;
                {a_q, d_q} <= launch_ad;
                state_q    <= S_SETUP;
              end else begin
                state_q    <= S_IDLE;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_SETUP: begin
            state_q <= S_STROBE;
            cnt_q   <= '0;
            iorq_q  <= 1'b0;
`ifdef PSG_READBACK_EN
            if (kind_q == K_DATA && cur_q.rd) rd_q <= 1'b0;
            else                              wr_q <= 1'b0;
`else
            wr_q    <= 1'b0;
`endif
          end
          S_STROBE: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= S_HOLD;
              iorq_q  <= 1'b1;
              wr_q    <= 1'b1;
`ifdef PSG_READBACK_EN
              rd_q    <= 1'b1;
              if (kind_q == K_DATA && cur_q.rd) begin
                rdata_q  <= q;
                rvalid_q <= 1'b1;
              end
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign iorq = iorq_q;
  assign wr   = wr_q;
  assign a    = a_q;
  assign d    = d_q;
  assign busy = !empty || (state_q != S_IDLE);

`ifdef PSG_READBACK_EN
  assign rd     = rd_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
`else
  logic unused_q;
  assign unused_q = ^q;
  assign rd     = 1'b1;
  assign rvalid = 1'b0;
  assign rdata  = 8'h00;
`endif

endmodule

// File: doc/psg_bus_master.md
# psg_bus_master

Bus initiator that drives the Z80-style I/O port protocol of the dual-AY (TurboSound) sound block, so that hardware sources (tune player, boot chime, test sequencer) can program either PSG without the CPU. It accepts register-write and register-read commands into a small FIFO. It expands each command into one to three I/O bus cycles on ports 0xFFFD and 0xBFFD. It sits beside the CPU and is multiplexed onto the sound block's iorq/wr/rd/a/d inputs by the top level.

## Interface

Parameters:

- FIFO_DEPTH, 4: command FIFO entries; a power of two, at least 2.
- STROBE_LEN, 2: ce ticks for which iorq/wr or iorq/rd stays low in each bus cycle; at least 1.

Ports:

- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  bus-timing enable; the bus FSM advances only on clocks with ce=1.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command is accepted on any clock where cmd_valid && cmd_ready.
- cmd_chip  in  1  target PSG: 0 = first, 1 = second.
- cmd_read  in  1  1 = read the register, 0 = write it.
- cmd_reg  in  4  AY register number, 0-15.
- cmd_val  in  8  write data; ignored for reads.
- rvalid  out  1  one-clock pulse when rdata is valid.
- rdata  out  8  read result; held until the next read completes.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- iorq  out  1  active-low I/O request.
- wr  out  1  active-low write strobe.
- rd  out  1  active-low read strobe.
- a  out  16  port address.
- d  out  8  write data.
- q  in  8  read data from the sound block.

## Operation

- Reset (asynchronous, immediate) sets:
  - outputs: iorq=wr=rd=1, a=16'hFFFF, d=8'h00, rvalid=0, rdata=8'h00, busy=0;
  - internal state: FIFO empty, FSM in IDLE, tracked chip = 0, which matches the responder's reset selection.
- Each command expands into bus cycles, in order:
  1. **CHIPSEL.** Issued only when cmd_chip differs from the tracked chip. OUT 0xFFFD with d = 8'hFF for chip 0 or 8'hFE for chip 1 (d[4]=1, d[0]=~chip). The tracked chip updates at the end of this cycle.
  2. **REGSEL.** Always issued. OUT 0xFFFD with d = {4'h0, cmd_reg}.
  3. **DATA.** For a write: OUT 0xBFFD with d = cmd_val. For a read: IN 0xFFFD with rd low and wr high.
- Every bus cycle uses the same phases, counted in ce ticks:
  - SETUP: 1 tick. a and d are driven; all strobes are high.
  - STROBE: STROBE_LEN ticks. iorq is low, plus wr (OUT) or rd (IN). a and d are stable.
  - HOLD: 1 tick. Strobes are high; a and d are unchanged.
- FSM states are IDLE, SETUP, STROBE and HOLD, plus a 2-bit cycle-kind register (CHIPSEL, REGSEL, DATA).
  - IDLE: on a ce tick with the FIFO non-empty, pop one entry. That tick is the SETUP tick of the first bus cycle.
  - After HOLD: go to SETUP of the next cycle, or to IDLE after DATA.
- Back in IDLE, a and d keep their last values. No write strobe is ever produced in IDLE.
- Read capture:
  - rdata samples q on the final STROBE tick of a read DATA cycle.
  - rvalid pulses for exactly one clock: the HOLD tick.
- The FIFO is written on the clock, independent of ce. Push and pop in the same clock are both honoured.
- When the FIFO is full, cmd_ready=0 and the offered command is not taken; no loss, no overwrite.

## Timing

- Each bus cycle lasts STROBE_LEN+2 ce ticks.
- Command cost with the default STROBE_LEN=2:
  - same chip: 8 ce ticks;
  - chip switch: 12 ce ticks.
- The first strobe falls STROBE_LEN... specifically, it falls 1 ce tick after the pop tick.
- Back-to-back commands have no idle gap: the next pop can occur on the ce tick immediately following the last HOLD.
- cmd_ready is combinational from FIFO occupancy only. It must not depend on cmd_valid.
- If ce is held low, the bus freezes mid-phase with all outputs stable. The FIFO still accepts commands.
- Reset asserted mid-cycle:
  - strobes return high asynchronously;
  - the partial command and all queued commands are discarded;
  - the tracked chip returns to 0.

## Configuration

- Macro PSG_READBACK_EN.
- **Defined:** read commands behave as described above.
- **Undefined:**
  - a command with cmd_read=1 is popped and discarded, with no bus cycles issued;
  - rd is tied high, rvalid is tied 0, rdata is tied 8'h00;
  - the q input is unused.

## Test plan

- **Reset:** assert reset mid-STROBE. Required: iorq/wr/rd go high in the same clock, a=16'hFFFF, busy=0, and a fresh write to chip 0 issues no CHIPSEL.
- **Same-chip write:** ce=1 every clock, write chip 0, reg 7, val 8'h38. Required: two bus cycles — OUT FFFD=07, then OUT BFFD=38 — each with a 2-clock wr/iorq low pulse; 8 clocks total.
- **Chip switch:** write chip 1 reg 0 val 8'h55, then chip 1 reg 1 val 8'hAA. Required:
  - first command: OUT FFFD=FE, FFFD=00, BFFD=55;
  - second command: no CHIPSEL;
  - then write chip 0. Required: CHIPSEL with FFFD=FF.
- **Readback (PSG_READBACK_EN):** read chip 0 reg 2 with q=8'h5A during the strobe. Required: OUT FFFD=02, then an IN FFFD cycle with rd low and wr high; rvalid pulses for one clock and rdata=8'h5A. Without the macro: no bus activity and rvalid stays 0.
- **Full FIFO and throughput:** hold ce low, push FIFO_DEPTH commands, then verify cmd_ready=0 and that a further push is refused. Raise ce. Required: all commands are issued in order with no gap ticks; busy falls on the clock after the final HOLD.
- **ce throttling:** ce=1 every 3rd clock. Required: strobe width is 3×STROBE_LEN clocks, and phase ordering is identical to the ce=1 case.
